// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding bridge between a cache controller and a
// fixed-latency block memory. A request is a write-back, a refill, or a
// write-back followed by a refill. The bridge runs each memory phase for
// MEM_LAT cycles, then pulses c_done for one cycle.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   c_rd_en        refill request (block read)
//   c_wr_en        write-back request (block write)
//   c_addr         refill block address
//   c_wb_addr      write-back (victim) block address
//   c_wr_blk       write-back block data
//   c_ready        bridge idle
//   c_done         one-cycle completion pulse
//   c_rd_blk       refill data, registered, held after c_done
//   m_addr         memory block address (64-byte aligned)
//   m_rd_en        memory read enable
//   m_wr_en        memory write enable (first WRITE cycle only)
//   m_wr_blk       memory write data
//   m_rd_blk       memory read data, valid one cycle after m_rd_en is sampled
//   dbg_state      current FSM state
//
// Handshake: a request is taken at a rising edge where c_ready is high and
// c_wr_en or c_rd_en is high. No back-pressure exists on the cache side
// beyond c_ready; enables seen while c_ready is low are dropped, not queued.
// Exactly one c_done pulse follows every accepted request.
module mem_bridge #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512,
  parameter int MEM_LAT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c_rd_en,
  input  logic                 c_wr_en,
  input  logic [PA_WIDTH-1:0]  c_addr,
  input  logic [PA_WIDTH-1:0]  c_wb_addr,
  input  logic [BLK_WIDTH-1:0] c_wr_blk,
  output logic                 c_ready,
  output logic                 c_done,
  output logic [BLK_WIDTH-1:0] c_rd_blk,
  output logic [PA_WIDTH-1:0]  m_addr,
  output logic                 m_rd_en,
  output logic                 m_wr_en,
  output logic [BLK_WIDTH-1:0] m_wr_blk,
  input  logic [BLK_WIDTH-1:0] m_rd_blk,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [PA_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                  c_ready_q, c_ready_d;
  logic                  c_done_q, c_done_d;
  logic [BLK_WIDTH-1:0]  c_rd_blk_q, c_rd_blk_d;
  logic [PA_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic                  m_rd_en_q, m_rd_en_d;
  logic                  m_wr_en_q, m_wr_en_d;
  logic [BLK_WIDTH-1:0]  m_wr_blk_q, m_wr_blk_d;

  logic [PA_WIDTH-1:0]   c_addr_al, c_wb_addr_al;

  // Block addresses are always 64-byte aligned.
  assign c_addr_al    = {c_addr[PA_WIDTH-1:6], 6'b0};
  assign c_wb_addr_al = {c_wb_addr[PA_WIDTH-1:6], 6'b0};

  // Outputs are registered: each *_d below is the value for the state
  // being entered, so the outputs line up with the state register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    c_ready_d  = 1'b0;
    c_done_d   = 1'b0;
    c_rd_blk_d = c_rd_blk_q;
    m_addr_d   = m_addr_q;
    m_rd_en_d  = 1'b0;
    m_wr_en_d  = 1'b0;
    m_wr_blk_d = m_wr_blk_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (c_wr_en) begin
          state_d    = WRITE;
          rd_pend_d  = c_rd_en;
          rd_addr_d  = c_addr_al;
          m_addr_d   = c_wb_addr_al;
          m_wr_blk_d = c_wr_blk;
          m_wr_en_d  = 1'b1;
        end else if (c_rd_en) begin
          state_d   = READ;
          rd_pend_d = 1'b0;
          rd_addr_d = c_addr_al;
          m_addr_d  = c_addr_al;
          m_rd_en_d = 1'b1;
        end else begin
          c_ready_d = 1'b1;
        end
      end
      WRITE: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rd_pend_q) begin
            state_d   = READ;
            m_addr_d  = rd_addr_q;
            m_rd_en_d = 1'b1;
          end else begin
            state_d  = RESP;
            c_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READ: begin
        if (cnt_q == LAST) begin
          // Memory data for the read is on m_rd_blk during the last cycle.
          cnt_d      = '0;
          state_d    = RESP;
          c_done_d   = 1'b1;
          c_rd_blk_d = m_rd_blk;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          m_rd_en_d = 1'b1;
        end
      end
      RESP: begin
        cnt_d     = '0;
        state_d   = IDLE;
        c_ready_d = 1'b1;
      end
      default: begin
        cnt_d     = '0;
        state_d   = IDLE;
        c_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      c_ready_q  <= 1'b1;
      c_done_q   <= 1'b0;
      c_rd_blk_q <= '0;
      m_addr_q   <= '0;
      m_rd_en_q  <= 1'b0;
      m_wr_en_q  <= 1'b0;
      m_wr_blk_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      c_ready_q  <= c_ready_d;
      c_done_q   <= c_done_d;
      c_rd_blk_q <= c_rd_blk_d;
      m_addr_q   <= m_addr_d;
      m_rd_en_q  <= m_rd_en_d;
      m_wr_en_q  <= m_wr_en_d;
      m_wr_blk_q <= m_wr_blk_d;
    end
  end

  assign c_ready   = c_ready_q;
  assign c_done    = c_done_q;
  assign c_rd_blk  = c_rd_blk_q;
  assign m_addr    = m_addr_q;
  assign m_rd_en   = m_rd_en_q;
  assign m_wr_en   = m_wr_en_q;
  assign m_wr_blk  = m_wr_blk_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Testbench for mem_bridge: directed steps followed by random transactions,
// checked against a transaction-level model of the bridge and its memory.
module tb_mem_bridge;

  localparam int PA  = 32;
  localparam int BW  = 512;
  localparam int LAT = 4;

  logic          clk, rst_n;
  logic          c_rd_en, c_wr_en;
  logic [PA-1:0] c_addr, c_wb_addr;
  logic [BW-1:0] c_wr_blk;
  logic          c_ready, c_done;
  logic [BW-1:0] c_rd_blk;
  logic [PA-1:0] m_addr;
  logic          m_rd_en, m_wr_en;
  logic [BW-1:0] m_wr_blk, m_rd_blk;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cyc = 0;

  // Reference model state
  logic [BW-1:0] ref_mem [logic [PA-1:0]];
  logic [BW-1:0] exp_rd_blk;
  logic [BW-1:0] exp_wr_blk;
  logic [PA-1:0] exp_m_addr;

  // Environment memory seen by the DUT
  logic [BW-1:0] mem [logic [PA-1:0]];

  mem_bridge #(.PA_WIDTH(PA), .BLK_WIDTH(BW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_rd_en(c_rd_en), .c_wr_en(c_wr_en),
    .c_addr(c_addr), .c_wb_addr(c_wb_addr), .c_wr_blk(c_wr_blk),
    .c_ready(c_ready), .c_done(c_done), .c_rd_blk(c_rd_blk),
    .m_addr(m_addr), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
    .m_wr_blk(m_wr_blk), .m_rd_blk(m_rd_blk), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] dflt(input logic [PA-1:0] a);
    return {16{a ^ 32'hA5A5_0000}};
  endfunction

  // Memory with one-cycle read latency.
  always @(posedge clk) begin
    if (m_wr_en) mem[m_addr] = m_wr_blk;
    if (m_rd_en) m_rd_blk <= mem.exists(m_addr) ? mem[m_addr] : dflt(m_addr);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] ref_rd(input logic [PA-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [PA-1:0] rand_addr();
    return PA'(($urandom_range(0, 7) << 6) | $urandom_range(0, 63));
  endfunction

  task automatic clear_inputs();
    c_wr_en = 1'b0; c_rd_en = 1'b0;
  endtask

  // ---------------- driver + scoreboard ----------------
  // Issues one request from an IDLE cycle and checks every cycle up to the
  // following IDLE cycle. Returns positioned in that IDLE cycle.
  task automatic do_req(input bit wr, input bit rd, input logic [PA-1:0] addr,
                        input logic [PA-1:0] wb, input logic [BW-1:0] blk, input bit noise);
    logic [PA-1:0] a_al, wb_al;
    int n_wr, n_rd;
    a_al  = {addr[PA-1:6], 6'b0};
    wb_al = {wb[PA-1:6], 6'b0};
    n_wr  = wr ? LAT : 0;
    n_rd  = rd ? LAT : 0;
    chk("ready_pre", c_ready, 1'b1);
    c_wr_en = wr; c_rd_en = rd; c_addr = addr; c_wb_addr = wb; c_wr_blk = blk;
    tick();
    if (wr) exp_wr_blk = blk;
    for (int i = 0; i < n_wr + n_rd; i++) begin
      chk("busy_ready", c_ready, 1'b0);
      chk("busy_done", c_done, 1'b0);
      if (i < n_wr) begin
        chk("wr_en", m_wr_en, (i == 0));
        chk("wr_rd_en", m_rd_en, 1'b0);
        chk("wr_addr", m_addr, wb_al);
        chk("wr_blk", m_wr_blk, exp_wr_blk);
      end else begin
        chk("rd_en", m_rd_en, 1'b1);
        chk("rd_wr_en", m_wr_en, 1'b0);
        chk("rd_addr", m_addr, a_al);
      end
      if (noise) begin
        c_wr_en = 1'($urandom_range(0, 1)); c_rd_en = 1'($urandom_range(0, 1));
        c_addr = $urandom(); c_wb_addr = $urandom(); c_wr_blk = rand_blk();
      end else begin
        clear_inputs();
      end
      tick();
    end
    clear_inputs();
    if (wr) ref_mem[wb_al] = blk;
    if (rd) exp_rd_blk = ref_rd(a_al);
    exp_m_addr = rd ? a_al : wb_al;
    chk("resp_done", c_done, 1'b1);
    chk("resp_ready", c_ready, 1'b0);
    chk("resp_rd_en", m_rd_en, 1'b0);
    chk("resp_wr_en", m_wr_en, 1'b0);
    chk("resp_addr", m_addr, exp_m_addr);
    chk("resp_wr_blk", m_wr_blk, exp_wr_blk);
    chk("resp_rd_blk", c_rd_blk, exp_rd_blk);
    done_cyc = cyc;
    tick();
    chk("idle_ready", c_ready, 1'b1);
    chk("idle_done", c_done, 1'b0);
    chk("idle_en", {m_rd_en, m_wr_en}, 2'b00);
    chk("idle_addr", m_addr, exp_m_addr);
    chk("idle_rd_blk", c_rd_blk, exp_rd_blk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, c_ready, 1'b1);
    chk({tag, "_done"}, c_done, 1'b0);
    chk({tag, "_en"}, {m_rd_en, m_wr_en}, 2'b00);
    chk({tag, "_rd_blk"}, c_rd_blk, '0);
    chk({tag, "_addr"}, m_addr, '0);
    chk({tag, "_wr_blk"}, m_wr_blk, '0);
  endtask

  // Holds reset a couple of cycles, releases it, then checks nothing stirs.
  task automatic reset_and_quiet(input string tag);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_reset_vals(tag);
    exp_rd_blk = '0; exp_wr_blk = '0; exp_m_addr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      chk({tag, "_q_done"}, c_done, 1'b0);
      chk({tag, "_q_en"}, {m_rd_en, m_wr_en}, 2'b00);
      chk({tag, "_q_ready"}, c_ready, 1'b1);
    end
  endtask

  localparam logic [BW-1:0] PAT_A = {16{32'hDEAD_BEEF}};
  localparam logic [BW-1:0] PAT_B = {8{64'h0123_4567_89AB_CDEF}};
  localparam logic [BW-1:0] PAT_C = {16{32'h5A5A_C3C3}};

  // ---------------- directed + random sequence ----------------
  initial begin
    int d1;
    bit wr, rd;
    rst_n = 1'b1;
    clear_inputs();
    c_addr = '0; c_wb_addr = '0; c_wr_blk = '0;
    exp_rd_blk = '0; exp_wr_blk = '0; exp_m_addr = '0;
    mem[32'h40] = PAT_A;
    ref_mem[32'h40] = PAT_A;
    #1 rst_n = 1'b0;
    #2;
    // Reset values apply before any clock edge.
    check_reset_vals("rst_async");
    tick();
    tick();
    rst_n = 1'b1;

    // Read of 0x40, accepted on the first edge after reset release.
    do_req(1'b0, 1'b1, 32'h40, 32'h0, '0, 1'b0);
    chk("read_a", c_rd_blk, PAT_A);

    // Misaligned read.
    do_req(1'b0, 1'b1, 32'h87, 32'h0, '0, 1'b0);

    // Write-back plus refill, then read the written-back block.
    do_req(1'b1, 1'b1, 32'h40, 32'h100, PAT_B, 1'b0);
    do_req(1'b0, 1'b1, 32'h100, 32'h0, '0, 1'b0);
    chk("readback_b", c_rd_blk, PAT_B);

    // Write-only leaves c_rd_blk alone; read it back afterwards.
    do_req(1'b1, 1'b0, 32'h0, 32'h33F, PAT_C, 1'b0);
    chk("wr_only_keep", c_rd_blk, PAT_B);
    do_req(1'b0, 1'b1, 32'h300, 32'h0, '0, 1'b0);
    chk("readback_c", c_rd_blk, PAT_C);

    // Busy ignore: c_wr_en pulse at 0x200 during READ.
    c_wr_en = 1'b0; c_rd_en = 1'b1; c_addr = 32'h40;
    tick();
    clear_inputs();
    tick();
    c_wr_en = 1'b1; c_wb_addr = 32'h200; c_wr_blk = PAT_C;
    chk("busy_rd_en", m_rd_en, 1'b1);
    tick();
    c_wr_en = 1'b0;
    chk("busy_no_wr", m_wr_en, 1'b0);
    chk("busy_addr", m_addr, 32'h40);
    tick();
    tick();
    chk("busy_one_done", c_done, 1'b1);
    chk("busy_blk", c_rd_blk, PAT_A);
    exp_rd_blk = PAT_A;
    tick();
    chk("busy_no_2nd_done", c_done, 1'b0);
    chk("busy_no_accept", c_ready, 1'b1);
    tick();
    chk("busy_no_2nd_done_b", c_done, 1'b0);
    chk("busy_idle_en", {m_rd_en, m_wr_en}, 2'b00);

    // Back-to-back reads.
    do_req(1'b0, 1'b1, 32'h40, 32'h0, '0, 1'b0);
    d1 = done_cyc;
    do_req(1'b0, 1'b1, 32'h87, 32'h0, '0, 1'b0);
    chk("b2b_gap", BW'(done_cyc - d1), BW'(LAT + 2));

    // No request: stays idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_stay_ready", c_ready, 1'b1);
      chk("idle_stay_en", {m_rd_en, m_wr_en, c_done}, 3'b000);
    end

    // Reset during READ cycle 2.
    c_rd_en = 1'b1; c_addr = 32'h40;
    tick();
    clear_inputs();
    tick();
    chk("pre_rst_rd_en", m_rd_en, 1'b1);
    reset_and_quiet("rst_rd");

    // Reset during WRITE cycle 1: m_wr_en must drop at once.
    c_wr_en = 1'b1; c_wb_addr = 32'h1C0; c_wr_blk = PAT_B;
    tick();
    clear_inputs();
    chk("pre_rst_wr_en", m_wr_en, 1'b1);
    reset_and_quiet("rst_wr");

    // Random transactions with input noise while busy.
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      do_req(wr, rd, rand_addr(), rand_addr(), rand_blk(), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter PA_WIDTH, default 32, physical address width.
REQ-002 Parameter BLK_WIDTH, default 512, cache block width (64-byte block).
REQ-003 Parameter MEM_LAT, default 4, cycles per memory access; legal range 2..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 c_rd_en  input  1  cache refill request (block read).
REQ-007 c_wr_en  input  1  cache write-back request (block write).
REQ-008 c_addr  input  PA_WIDTH  refill block address.
REQ-009 c_wb_addr  input  PA_WIDTH  write-back (victim) block address.
REQ-010 c_wr_blk  input  BLK_WIDTH  write-back block data.
REQ-011 c_ready  output  1  bridge idle; a request is accepted only while high.
REQ-012 c_done  output  1  one-cycle pulse: request complete.
REQ-013 c_rd_blk  output  BLK_WIDTH  registered refill data; valid while c_done is high, then held.
REQ-014 m_addr  output  PA_WIDTH  memory block address.
REQ-015 m_rd_en  output  1  memory read enable.
REQ-016 m_wr_en  output  1  memory write enable.
REQ-017 m_wr_blk  output  BLK_WIDTH  memory write data.
REQ-018 m_rd_blk  input  BLK_WIDTH  memory read data; valid one cycle after m_rd_en is sampled.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, WRITE, READ and RESP.
REQ-020 c_ready SHALL be 1 in IDLE only.
REQ-021 In IDLE with c_wr_en=1, the bridge SHALL latch c_addr, c_wb_addr and c_wr_blk and go to WRITE, regardless of c_rd_en.
REQ-022 In IDLE with c_rd_en=1 and c_wr_en=0, the bridge SHALL latch c_addr and go to READ.
REQ-023 In IDLE with neither enable asserted, the bridge SHALL stay in IDLE.
REQ-024 Latched addresses SHALL have bits [5:0] forced to 0, so m_addr is always 64-byte aligned.
REQ-025 WRITE SHALL last exactly MEM_LAT cycles: m_addr = latched wb address and m_wr_blk = latched data for all cycles; m_wr_en = 1 in the first cycle only.
REQ-026 On leaving WRITE, the FSM SHALL go to READ if c_rd_en was high at acceptance, else to RESP.
REQ-027 READ SHALL last exactly MEM_LAT cycles with m_rd_en = 1 and m_addr = latched refill address throughout.
REQ-028 c_rd_blk SHALL capture m_rd_blk at the clock edge that ends the last READ cycle.
REQ-029 RESP SHALL last one cycle with c_done = 1 and SHALL then return to IDLE.
REQ-030 Cycle counts from the accepting edge: read-only, c_done in cycle MEM_LAT+1; write-only, c_done in cycle MEM_LAT+1; write+read, c_done in cycle 2*MEM_LAT+1.
REQ-031 A write-only request SHALL leave c_rd_blk unchanged.
REQ-032 Requests and input changes outside IDLE SHALL be ignored: no queueing and no effect on latched values.
REQ-033 The cycle counter SHALL be ceil(log2(MEM_LAT+1)) bits wide and SHALL reset to 0 on every state entry.
REQ-034 m_rd_en and m_wr_en SHALL never be 1 in the same cycle.
REQ-035 In IDLE and RESP, m_rd_en and m_wr_en SHALL be 0; m_addr and m_wr_blk SHALL hold their last values.

Reset
REQ-036 While rst_n = 0, the FSM SHALL be in IDLE and the counter SHALL be 0.
REQ-037 While rst_n = 0, c_ready SHALL be 1, c_done, m_rd_en and m_wr_en SHALL be 0, and c_rd_blk, m_addr and m_wr_blk SHALL be all-zero; this takes effect without waiting for a clock edge.
REQ-038 Reset asserted mid-request SHALL discard the request: no c_done and no further memory enables, and m_wr_en SHALL drop immediately.
REQ-039 After reset deassertion, a request SHALL be accepted on the first rising edge with c_ready = 1.

Verification
REQ-040 Read: c_rd_en=1, c_addr=0x0000_0040; memory block at 0x40 = pattern A -> m_rd_en high for 4 cycles with m_addr=0x40, c_done in cycle 5, c_rd_blk=A.
REQ-041 Misaligned read: c_addr=0x0000_0087 -> m_addr=0x0000_0080.
REQ-042 Write-back plus refill: c_wr_en=c_rd_en=1, c_wb_addr=0x100, c_addr=0x40, c_wr_blk=B -> a single-cycle m_wr_en at 0x100, then 4 read cycles at 0x40, c_done in cycle 9; a later read of 0x100 returns B.
REQ-043 Busy ignore: during READ, pulse c_wr_en with c_wb_addr=0x200 -> no m_wr_en, m_addr stays 0x40, exactly one c_done.
REQ-044 Reset mid-READ: rst_n=0 in READ cycle 2 -> m_rd_en=0 and c_ready=1 immediately, c_rd_blk=0, and no c_done after release.
REQ-045 Back-to-back: a new c_rd_en in the IDLE cycle after c_done -> accepted immediately, with the second c_done exactly MEM_LAT+2 cycles after the first.
